pc_predictor: RTL and testbench

Parametrised fetch-PC generator with a direct-mapped branch target buffer and 2-bit saturating direction counters. It sits at the head of the IF stage: it drives the fetch address and the prediction attached to it, accepts resolved-branch updates from EX, and produces the mispredict redirect that flushes the pipeline. It generalises the current single-bit BTB PC register with configurable depth, reset vector, counter hysteresis, unconditional-jump tracking and a prediction-disable mode.

---
 rtl/pc_predictor.sv | 118 +++++++++++
 tb/tb_pc_predictor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_predictor.sv
// Fetch-PC generator with a direct-mapped BTB and 2-bit saturating direction counters.
// Drives the fetch address, its prediction, and the mispredict redirect from EX updates.
module pc_predictor #(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          BTB_ENTRIES = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter bit                   PRED_EN     = 1'b1,
  parameter int unsigned          STALL_WIDTH = 6
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic [STALL_WIDTH-1:0] stall,
  input  logic                   update_valid_in,
  input  logic [PC_WIDTH-1:0]    update_pc_in,
  input  logic [PC_WIDTH-1:0]    update_target_in,
  input  logic                   update_taken_in,
  input  logic                   update_is_jump_in,
  input  logic                   update_pred_taken_in,
  input  logic [PC_WIDTH-1:0]    update_pred_target_in,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   pred_taken_out,
  output logic [PC_WIDTH-1:0]    pred_target_out,
  output logic                   incorrect_out
);

  localparam int unsigned IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_BITS = PC_WIDTH - IDX_BITS - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_BITS-1:0]    tag_q    [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]    target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic                   jump_q   [BTB_ENTRIES];

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic [1:0]          ctr_next;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                unused_stall_bits;

  assign unused_stall_bits = ^stall;

  assign lk_idx = pc_out[IDX_BITS+1:2];
  assign lk_tag = pc_out[PC_WIDTH-1:IDX_BITS+2];
  assign up_idx = update_pc_in[IDX_BITS+1:2];
  assign up_tag = update_pc_in[PC_WIDTH-1:IDX_BITS+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // With prediction disabled the table outputs are never consulted.
  always_comb begin
    pred_taken_out  = 1'b0;
    pred_target_out = '0;
    if (PRED_EN) begin
      if (valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) &&
          (jump_q[lk_idx] || ctr_q[lk_idx][1])) begin
        pred_taken_out  = 1'b1;
        pred_target_out = target_q[lk_idx];
      end
    end
  end

  assign seq_pc = pred_taken_out ? pred_target_out : pc_out + PC_WIDTH'(4);

  assign incorrect_out = update_valid_in &&
                         ((update_taken_in != update_pred_taken_in) ||
                          (update_taken_in && (update_target_in != update_pred_target_in)));

  assign redirect_pc = update_taken_in ? update_target_in : update_pc_in + PC_WIDTH'(4);

  always_comb begin
    ctr_next = ctr_q[up_idx];
    if (update_taken_in) begin
      if (ctr_q[up_idx] != 2'b11) ctr_next = ctr_q[up_idx] + 2'd1;
    end else begin
      if (ctr_q[up_idx] != 2'b00) ctr_next = ctr_q[up_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_out <= RESET_PC;
    end else if (rdy_in) begin
      if (incorrect_out) pc_out <= redirect_pc;
      else if (!stall[0]) pc_out <= seq_pc;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (rdy_in && update_valid_in) begin
      if (update_is_jump_in) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target_in;
        ctr_q[up_idx]    <= 2'b11;
        jump_q[up_idx]   <= 1'b1;
      end else if (up_hit) begin
        ctr_q[up_idx]  <= ctr_next;
        jump_q[up_idx] <= 1'b0;
        if (update_taken_in) target_q[up_idx] <= update_target_in;
      end else if (update_taken_in) begin
        // Taken miss replaces whatever entry aliases to this index.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target_in;
        ctr_q[up_idx]    <= 2'b10;
        jump_q[up_idx]   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_predictor.sv
// Directed bench for pc_predictor: sequential fetch, learning, hysteresis, aliasing,
// jump target change, redirect priority, freeze, and a prediction-disabled build.
module tb_pc_predictor;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  stall;
  logic        update_valid_in;
  logic [31:0] update_pc_in;
  logic [31:0] update_target_in;
  logic        update_taken_in;
  logic        update_is_jump_in;
  logic        update_pred_taken_in;
  logic [31:0] update_pred_target_in;

  logic [31:0] pc_out, pred_target_out;
  logic        pred_taken_out, incorrect_out;
  logic [31:0] pc2, pred_target2;
  logic        pred_taken2, incorrect2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk_in = ~clk_in;

  pc_predictor #(.PC_WIDTH(32), .BTB_ENTRIES(64)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall(stall),
    .update_valid_in(update_valid_in), .update_pc_in(update_pc_in),
    .update_target_in(update_target_in), .update_taken_in(update_taken_in),
    .update_is_jump_in(update_is_jump_in), .update_pred_taken_in(update_pred_taken_in),
    .update_pred_target_in(update_pred_target_in),
    .pc_out(pc_out), .pred_taken_out(pred_taken_out),
    .pred_target_out(pred_target_out), .incorrect_out(incorrect_out)
  );

  pc_predictor #(.PC_WIDTH(32), .BTB_ENTRIES(64), .RESET_PC(32'h100), .PRED_EN(1'b0)) dut_nopred (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall(stall),
    .update_valid_in(update_valid_in), .update_pc_in(update_pc_in),
    .update_target_in(update_target_in), .update_taken_in(update_taken_in),
    .update_is_jump_in(update_is_jump_in), .update_pred_taken_in(update_pred_taken_in),
    .update_pred_target_in(update_pred_target_in),
    .pc_out(pc2), .pred_taken_out(pred_taken2),
    .pred_target_out(pred_target2), .incorrect_out(incorrect2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                     input logic jump, input logic ptaken, input logic [31:0] ptgt);
    update_valid_in       = 1'b1;
    update_pc_in          = pc;
    update_target_in      = tgt;
    update_taken_in       = taken;
    update_is_jump_in     = jump;
    update_pred_taken_in  = ptaken;
    update_pred_target_in = ptgt;
    #1;
  endtask

  task automatic idle();
    update_valid_in       = 1'b0;
    update_pc_in          = '0;
    update_target_in      = '0;
    update_taken_in       = 1'b0;
    update_is_jump_in     = 1'b0;
    update_pred_taken_in  = 1'b0;
    update_pred_target_in = '0;
    #1;
  endtask

  // Forces fetch to x via a not-taken mispredict at x-4 (miss, so no table write).
  task automatic go(input logic [31:0] x);
    upd(x - 32'd4, '0, 1'b0, 1'b0, 1'b1, '0);
    tick();
    idle();
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b0;
    stall  = '0;
    idle();
    tick();
    check("reset_pc", pc_out, 32'h0);
    check("reset_pred", {31'b0, pred_taken_out}, 32'h0);
    check("reset_tgt", pred_target_out, 32'h0);
    check("reset_inc", {31'b0, incorrect_out}, 32'h0);
    check("reset_pc_alt", pc2, 32'h100);
    rst_in = 1'b0;
    rdy_in = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_pc", pc_out, 32'(4 * i));
      check("seq_pred", {31'b0, pred_taken_out}, 32'h0);
    end
    stall = 6'b000001;
    tick();
    check("stall_hold", pc_out, 32'hC);

    // Taken miss while stalled: redirect wins over stall.
    upd(32'h10, 32'h40, 1'b1, 1'b0, 1'b0, '0);
    check("learn_inc", {31'b0, incorrect_out}, 32'h1);
    tick();
    idle();
    check("learn_redirect", pc_out, 32'h40);
    go(32'h10);
    check("learn_at", pc_out, 32'h10);
    check("learn_pred", {31'b0, pred_taken_out}, 32'h1);
    check("learn_tgt", pred_target_out, 32'h40);
    check("nopred_pc", pc2, 32'h10);
    check("nopred_pred", {31'b0, pred_taken2}, 32'h0);
    stall = '0;
    tick();
    check("follow_pred", pc_out, 32'h40);
    check("nopred_seq", pc2, 32'h14);
    stall = 6'b000001;

    // Correct prediction: ctr 10 -> 11.
    upd(32'h10, 32'h40, 1'b1, 1'b0, 1'b1, 32'h40);
    check("correct_noinc", {31'b0, incorrect_out}, 32'h0);
    tick();
    idle();
    upd(32'h10, '0, 1'b0, 1'b0, 1'b1, 32'h40);
    check("nt1_inc", {31'b0, incorrect_out}, 32'h1);
    tick();
    idle();
    check("nt1_redirect", pc_out, 32'h14);
    go(32'h10);
    check("hyst_still_taken", {31'b0, pred_taken_out}, 32'h1);
    upd(32'h10, '0, 1'b0, 1'b0, 1'b1, 32'h40);
    check("same_cycle_old", {31'b0, pred_taken_out}, 32'h1);
    check("nt2_inc", {31'b0, incorrect_out}, 32'h1);
    tick();
    idle();
    check("nt2_redirect", pc_out, 32'h14);
    go(32'h10);
    check("hyst_not_taken", {31'b0, pred_taken_out}, 32'h0);
    check("hyst_tgt_zero", pred_target_out, 32'h0);

    // Retrain 0x10 to taken (ctr 01 -> 10), then alias it out with 0x110.
    upd(32'h10, 32'h40, 1'b1, 1'b0, 1'b0, '0);
    tick();
    idle();
    go(32'h10);
    check("retrain_pred", {31'b0, pred_taken_out}, 32'h1);
    upd(32'h110, 32'h200, 1'b1, 1'b1, 1'b0, '0);
    check("alias_inc", {31'b0, incorrect_out}, 32'h1);
    tick();
    idle();
    check("alias_redirect", pc_out, 32'h200);
    go(32'h110);
    check("alias_pred", {31'b0, pred_taken_out}, 32'h1);
    check("alias_tgt", pred_target_out, 32'h200);
    go(32'h10);
    check("alias_evicted", {31'b0, pred_taken_out}, 32'h0);

    // Jump target change.
    upd(32'h20, 32'h80, 1'b1, 1'b1, 1'b0, '0);
    tick();
    idle();
    check("jal_redirect", pc_out, 32'h80);
    upd(32'h20, 32'h84, 1'b1, 1'b1, 1'b1, 32'h80);
    check("jalr_inc", {31'b0, incorrect_out}, 32'h1);
    tick();
    idle();
    check("jalr_redirect", pc_out, 32'h84);
    go(32'h20);
    check("jalr_pred", {31'b0, pred_taken_out}, 32'h1);
    check("jalr_tgt", pred_target_out, 32'h84);

    // Freeze: rdy_in=0 holds pc and tables while incorrect_out still reports.
    stall  = '0;
    rdy_in = 1'b0;
    upd(32'h20, 32'h100, 1'b1, 1'b1, 1'b1, 32'h84);
    check("freeze_inc", {31'b0, incorrect_out}, 32'h1);
    tick();
    check("freeze_pc", pc_out, 32'h20);
    check("freeze_tgt", pred_target_out, 32'h84);
    rdy_in = 1'b1;
    tick();
    idle();
    check("release_pc", pc_out, 32'h100);
    go(32'h20);
    check("release_tgt", pred_target_out, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
